// File: rtl/fir_pkg.sv
// Shared constants for the audio sample path: system/sample rates, the
// sample-clock generator state encoding and a constant-friendly clog2.
package fir_pkg;

    localparam int CLK_HZ_SYS  = 100_000_000;
    localparam int FS_HZ_AUDIO = 48_000;

    typedef enum logic [1:0] {
        SCG_IDLE  = 2'd0,
        SCG_RUN   = 2'd1,
        SCG_DRAIN = 2'd2
    } scg_state_e;

    // Smallest n with 2**n >= value; usable in parameter expressions.
    function automatic int clog2(input longint value);
        int     result;
        longint span;
        result = 32'sd0;
        span   = 64'sd1;
        while (span < value) begin
            span   = span * 64'sd2;
            result = result + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sample_clk_gen_frac_step.sv
// Bresenham phase accumulator: adds INC per advance and reports a wrap
// whenever the sum reaches MOD, keeping acc in [0, MOD-1].
module frac_step
    import fir_pkg::*;
#(
    parameter int INC   = 2 * FS_HZ_AUDIO,
    parameter int MOD   = CLK_HZ_SYS,
    parameter int ACC_W = clog2(longint'(MOD) + longint'(INC))
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    input  logic             clear,
    output logic [ACC_W-1:0] acc,
    output logic             wrap
);

    localparam logic [ACC_W-1:0] INC_V = ACC_W'(INC);
    localparam logic [ACC_W-1:0] MOD_V = ACC_W'(MOD);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] sum_s;

    // Next accumulator value; clear wins but the wrap of the same step is still reported.
    always_comb begin
        sum_s = acc_q + INC_V;
        wrap  = advance && (sum_s >= MOD_V);
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (advance) begin
            if (wrap) begin
                acc_d = sum_s - MOD_V;
            end else begin
                acc_d = sum_s;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/sample_clk_gen.sv
// Sample-rate clock generator: fractional divider of clk_fast producing a
// registered square wave with edge strobes and glitch-free start/stop.
module sample_clk_gen
    import fir_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_SYS,
    parameter int FS_HZ  = FS_HZ_AUDIO
) (
    input  logic clk_fast,
    input  logic rst_n,
    input  logic enable,
    output logic sample_clk,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic running
);

    localparam int INC   = 2 * FS_HZ;
    localparam int ACC_W = clog2(longint'(CLK_HZ) + longint'(INC));
    localparam logic [ACC_W-1:0] MOD_V = ACC_W'(CLK_HZ);

    generate
        if ((FS_HZ == 0) || (2 * FS_HZ > CLK_HZ)) begin : g_bad_rate
            $error("sample_clk_gen: FS_HZ must be nonzero and 2*FS_HZ <= CLK_HZ");
        end
    endgenerate

    scg_state_e       state_q;
    scg_state_e       state_d;
    logic             sample_clk_q;
    logic             sample_clk_d;
    logic             rise_pulse_q;
    logic             rise_pulse_d;
    logic             fall_pulse_q;
    logic             fall_pulse_d;
    logic             running_q;
    logic             running_d;
    logic             advance_s;
    logic             clear_s;
    logic             wrap_s;
    logic             acc_bad_s;
    logic [ACC_W-1:0] acc_s;

    frac_step #(
        .INC   (INC),
        .MOD   (CLK_HZ),
        .ACC_W (ACC_W)
    ) u_frac_step (
        .clk     (clk_fast),
        .rst_n   (rst_n),
        .advance (advance_s),
        .clear   (clear_s),
        .acc     (acc_s),
        .wrap    (wrap_s)
    );

    // An accumulator outside [0, CLK_HZ-1] can only come from corruption; re-seed it.
    assign acc_bad_s = (acc_s >= MOD_V);

    // FSM next state, accumulator control and next output values.
    always_comb begin
        state_d      = state_q;
        sample_clk_d = sample_clk_q;
        rise_pulse_d = 1'b0;
        fall_pulse_d = 1'b0;
        advance_s    = 1'b0;
        clear_s      = acc_bad_s;
        case (state_q)
            SCG_IDLE: begin
                clear_s      = 1'b1;
                sample_clk_d = 1'b0;
                if (enable) begin
                    state_d = SCG_RUN;
                end else begin
                    state_d = SCG_IDLE;
                end
            end
            SCG_RUN: begin
                if (!enable && !sample_clk_q) begin
                    state_d = SCG_IDLE;
                    clear_s = 1'b1;
                end else begin
                    advance_s = 1'b1;
                    if (wrap_s) begin
                        sample_clk_d = ~sample_clk_q;
                        rise_pulse_d = ~sample_clk_q;
                        fall_pulse_d = sample_clk_q;
                    end else begin
                        sample_clk_d = sample_clk_q;
                    end
                    // A stop request landing on the falling step goes straight to IDLE.
                    if (enable) begin
                        state_d = SCG_RUN;
                    end else if (wrap_s) begin
                        state_d = SCG_IDLE;
                        clear_s = 1'b1;
                    end else begin
                        state_d = SCG_DRAIN;
                    end
                end
            end
            SCG_DRAIN: begin
                advance_s = 1'b1;
                if (wrap_s) begin
                    sample_clk_d = ~sample_clk_q;
                    rise_pulse_d = ~sample_clk_q;
                    fall_pulse_d = sample_clk_q;
                end else begin
                    sample_clk_d = sample_clk_q;
                end
                if (enable) begin
                    state_d = SCG_RUN;
                end else if (wrap_s) begin
                    state_d = SCG_IDLE;
                    clear_s = 1'b1;
                end else begin
                    state_d = SCG_DRAIN;
                end
            end
            default: begin
                state_d      = SCG_IDLE;
                sample_clk_d = 1'b0;
                clear_s      = 1'b1;
            end
        endcase
        running_d = (state_d == SCG_RUN) || (state_d == SCG_DRAIN);
    end

    // State and output registers.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SCG_IDLE;
            sample_clk_q <= 1'b0;
            rise_pulse_q <= 1'b0;
            fall_pulse_q <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_clk_q <= sample_clk_d;
            rise_pulse_q <= rise_pulse_d;
            fall_pulse_q <= fall_pulse_d;
            running_q    <= running_d;
        end
    end

    assign sample_clk = sample_clk_q;
    assign rise_pulse = rise_pulse_q;
    assign fall_pulse = fall_pulse_q;
    assign running    = running_q;

endmodule

// File: doc/sample_clk_gen.md
# sample_clk_gen

Generates the 48 kHz sample-rate clock, as a registered square wave, from the 100 MHz system clock. It uses an exact fractional (Bresenham) divider, so the long-term rate is CLK_HZ/FS_HZ with no drift. It drives the ADC/DAC sample clock pin and the FIR sample-strobe input. Single-cycle edge pulses are also provided, so logic in the fast domain can act on sample boundaries without resynchronizing the generated clock. Start and stop are glitch-free: no high phase is ever truncated.

## Interface
- CLK_HZ, 100_000_000: frequency of clk_fast in Hz.
- FS_HZ, 48_000: target sample-clock frequency in Hz. Elaboration error if 2*FS_HZ > CLK_HZ or FS_HZ = 0.
- clk_fast  input  1  system clock. Everything is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  level request to run the sample clock.
- sample_clk  output  1  generated sample clock. Registered, glitch-free.
- rise_pulse  output  1  high for exactly the first clk_fast cycle in which sample_clk is high.
- fall_pulse  output  1  high for exactly the first clk_fast cycle in which sample_clk is low after a high phase.
- running  output  1  high while in RUN or DRAIN.

## Operation
- Constants:
  - INC = 2*FS_HZ.
  - ACC_W = clog2(CLK_HZ + INC), which is 27 bits at the defaults.
  - The accumulator acc is unsigned ACC_W bits.
- States:
  - IDLE: acc = 0, sample_clk = 0.
  - RUN: generating.
  - DRAIN: stop requested; finish the current high phase.
- Step rule, applied in RUN and DRAIN on every clock:
  - s = acc + INC.
  - If s >= CLK_HZ: acc <= s - CLK_HZ, and sample_clk toggles.
  - Otherwise: acc <= s.
  - acc therefore never exceeds CLK_HZ-1.
- Transitions:
  - IDLE, enable=1 → RUN. acc starts at 0.
  - RUN, enable=0, sample_clk=0 → IDLE on the next edge. acc is cleared and no pulse is issued.
  - RUN, enable=0, sample_clk=1 → DRAIN.
  - DRAIN, step toggles sample_clk low → IDLE, with acc cleared and fall_pulse asserted.
  - DRAIN, enable=1 → RUN. acc and sample_clk are untouched, so the phase continues with no extra or missing edge.
  - If a toggle and enable=1 occur in the same DRAIN cycle, RUN wins and the toggle still happens.
- Restart from IDLE always begins at phase 0, so the first half-period is deterministic.
- rise_pulse and fall_pulse are registered alongside sample_clk. They are never both high, and never high in IDLE.

## Timing
- Reset value of every output is 0; state resets to IDLE and acc to 0. Reset mid-run drops sample_clk to 0 immediately, which is asynchronous and accepted.
- enable sampled high at edge k gives running=1 from edge k.
- First rising edge:
  - sample_clk=1 and rise_pulse=1 after edge k+1042 at the defaults.
  - In general after edge k+ceil(CLK_HZ/INC).
- Half-periods at the defaults repeat 1042, 1042, 1041 cycles:
  - Periods are 2084, 2083, 2083 cycles.
  - Exactly 3 rising edges per 6250 cycles, which is exactly 48 kHz.
- Minimum half-period is floor(CLK_HZ/INC) cycles; there is no jitter beyond ±1 cycle.
- Stop latency:
  - 1 cycle when sample_clk is low.
  - Otherwise up to the remaining high half-period.

## Structure
- Shared package fir_pkg holds:
  - CLK_HZ_SYS and FS_HZ_AUDIO constants (also used by the FIR control).
  - The sample_clk_gen state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2).
  - A clog2 function.
- One sub-module, frac_step:
  - Combinational plus acc register.
  - Inputs: advance, clear.
  - Outputs: acc, wrap.
  - Parameters: INC, MOD.
  - The sample_clk_gen top holds the FSM and the output registers.

## Test plan
- Reset, then enable=1 at edge 0 → first rise_pulse at edge 1042; subsequent rising-edge spacings 2084, 2083, 2083, repeating.
- Run 625,000 cycles → exactly 300 rise_pulses and 300 fall_pulses. Pulses are single-cycle, never coincident, and rise_pulse always coincides with the 0→1 transition of sample_clk.
- Drop enable 10 cycles into a high phase → sample_clk stays high the full half-period, then falls with fall_pulse. running goes 0 the same cycle; no further edges.
- Drop enable during a low phase → IDLE next cycle with no pulse. Re-enable → first rise again exactly 1042 cycles later.
- Drop enable in a high phase, then re-assert it 5 cycles later → the edge sequence is identical to an uninterrupted run.
- Assert rst_n=0 mid-high-phase → all outputs 0 immediately. After release with enable held high, the first rise occurs 1042 cycles after the first sampling edge.
